global_mem_arbiter: RTL

- Shares a single global-memory port between NUM_CORES gpuCore instances.
- Each core raises a level read or write request together with its MAR and MDR, then holds it until it sees a one-cycle done pulse.
- The arbiter grants one core at a time, round-robin, and runs one transaction on the memory port.
- It returns read data alongside the done pulse, and aborts with an error if memory stops responding.

---
 rtl/global_mem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/global_mem_arbiter.sv
// Round-robin arbiter sharing one global-memory port between NUM_CORES cores.
// One transaction at a time: grant in IDLE, wait for memAck (or timeout) in BUSY, pulse done in RESPOND.
module global_mem_arbiter #(
  parameter int          NUM_CORES = 4,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [NUM_CORES-1:0]    coreReadReq,
  input  logic [NUM_CORES-1:0]    coreWriteReq,
  input  logic [32*NUM_CORES-1:0] coreAddr,
  input  logic [32*NUM_CORES-1:0] coreWData,
  output logic [NUM_CORES-1:0]    coreReadDone,
  output logic [NUM_CORES-1:0]    coreWriteDone,
  output logic [31:0]             coreRData,
  output logic                    memReq,
  output logic                    memWe,
  output logic [31:0]             memAddr,
  output logic [31:0]             memWData,
  input  logic [31:0]             memRData,
  input  logic                    memAck,
  output logic                    busy,
  output logic [3:0]              grantId,
  output logic                    errFlag
);

  if (NUM_CORES < 2 || NUM_CORES > 16) begin : g_bad_num_cores
    $error("global_mem_arbiter: NUM_CORES must be in 2..16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  // Per-core views padded to 16 entries so a 4-bit grant index always selects cleanly.
  logic [15:0] req_pad;
  logic [15:0] rd_pad;
  logic [31:0] addr_arr  [16];
  logic [31:0] wdata_arr [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_pad
    if (gi < NUM_CORES) begin : g_real
      assign req_pad[gi]   = coreReadReq[gi] | coreWriteReq[gi];
      assign rd_pad[gi]    = coreReadReq[gi];
      assign addr_arr[gi]  = coreAddr[32*gi +: 32];
      assign wdata_arr[gi] = coreWData[32*gi +: 32];
    end else begin : g_empty
      assign req_pad[gi]   = 1'b0;
      assign rd_pad[gi]    = 1'b0;
      assign addr_arr[gi]  = '0;
      assign wdata_arr[gi] = '0;
    end
  end

  state_t                 state_q, state_d;
  logic [3:0]             grant_q, grant_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [NUM_CORES-1:0]   read_done_q, read_done_d;
  logic [NUM_CORES-1:0]   write_done_q, write_done_d;

  logic                   pick_found;
  logic [3:0]             pick_idx;
  logic [4:0]             cand;
  logic [NUM_CORES-1:0]   grant_onehot;

  // Scan lastGrant+1, lastGrant+2, ... wrapping, first requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_q;
    cand       = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = {1'b0, grant_q} + 5'(k);
      if (cand >= 5'(NUM_CORES)) cand = cand - 5'(NUM_CORES);
      if (!pick_found && req_pad[cand[3:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[3:0];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_CORES; i++) grant_onehot[i] = (grant_q == 4'(i));
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rdata_d      = '0;
    read_done_d  = '0;
    write_done_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          mem_addr_d  = addr_arr[pick_idx];
          mem_wdata_d = wdata_arr[pick_idx];
          mem_we_d    = ~rd_pad[pick_idx];
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (memAck || cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          state_d   = RESPOND;
          if (mem_we_q) write_done_d = grant_onehot;
          else          read_done_d  = grant_onehot;
          if (!memAck) begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
          end else if (!mem_we_q) begin
            rdata_d = memRData;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      grant_q      <= 4'(NUM_CORES - 1);
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      read_done_q  <= '0;
      write_done_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
    end
  end

  assign coreReadDone  = read_done_q;
  assign coreWriteDone = write_done_q;
  assign coreRData     = rdata_q;
  assign memReq        = mem_req_q;
  assign memWe         = mem_we_q;
  assign memAddr       = mem_addr_q;
  assign memWData      = mem_wdata_q;
  assign busy          = (state_q != IDLE);
  assign grantId       = grant_q;
  assign errFlag       = err_q;

endmodule
